phase_sequencer: RTL



---
 rtl/phase_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Sequences the dual-rail PH0/PH1/PH2 phases through a return-to-zero handshake on ack_in.
// Define PHASE_SEQ_WATCHDOG_EN to build the completion watchdog (err_timeout, clr_err, ERROR).
module phase_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SPACER_CYCLES = 1,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             clr_err,
    input  logic             ack_in,
    output logic [1:0]       PH0,
    output logic [1:0]       PH1,
    output logic [1:0]       PH2,
    output logic [1:0]       phase,
    output logic             busy,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             err_timeout
);
    localparam int unsigned GAP_W = (SPACER_CYCLES > 1) ? $clog2(SPACER_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StRelease,
        StGap,
        StError
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_s;
    logic [1:0]             phase_q, phase_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   armed_q, armed_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [5:0]             ph_q, ph_d;
    logic                   busy_q, busy_d;

`ifdef PHASE_SEQ_WATCHDOG_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    assign err_timeout = err_q;
`else
    logic unused_wdog;

    assign unused_wdog = clr_err ^ (TIMEOUT == 0);
    assign err_timeout = 1'b0;
`endif

    assign ack_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], ack_in};
        state_d = state_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
`ifdef PHASE_SEQ_WATCHDOG_EN
        wait_d  = wait_q;
        err_d   = err_q;
`endif

        // armed_q: ack_s has been seen low since ASSERT entry, so a high ack_s is a fresh edge
        unique case (state_q)
            StIdle: begin
                if (run || step) begin
                    state_d = StAssert;
                    phase_d = 2'd0;
                    armed_d = ~ack_s;
                end
            end
            StAssert: begin
                armed_d = armed_q | ~ack_s;
                if (ack_s && armed_q) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!ack_s) begin
                    state_d = StGap;
                    gap_d   = GAP_W'(SPACER_CYCLES - 1);
                end
            end
            StGap: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (phase_q != 2'd2) begin
                    state_d = StAssert;
                    phase_d = phase_q + 2'd1;
                    armed_d = ~ack_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (run) begin
                        state_d = StAssert;
                        phase_d = 2'd0;
                        armed_d = ~ack_s;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StError: begin
`ifdef PHASE_SEQ_WATCHDOG_EN
                if (clr_err && !ack_s) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase

`ifdef PHASE_SEQ_WATCHDOG_EN
        if ((state_q == StAssert || state_q == StRelease) && wait_q == WAIT_W'(TIMEOUT)) begin
            state_d = StError;
            err_d   = 1'b1;
        end
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (state_q == StAssert || state_q == StRelease) begin
            wait_d = wait_q + 1'b1;
        end
`endif

        // Outputs are decoded from the next state so they change on the same edge as the FSM
        ph_d = 6'b00_00_00;
        if (state_d == StAssert) begin
            ph_d = 6'b01_01_01;
            case (phase_d)
                2'd0:    ph_d[5:4] = 2'b10;
                2'd1:    ph_d[3:2] = 2'b10;
                default: ph_d[1:0] = 2'b10;
            endcase
        end
        busy_d = (state_d != StIdle) && (state_d != StError);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= StIdle;
            phase_q <= 2'd0;
            gap_q   <= '0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            ph_q    <= 6'b00_00_00;
            busy_q  <= 1'b0;
`ifdef PHASE_SEQ_WATCHDOG_EN
            wait_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            busy_q  <= busy_d;
`ifdef PHASE_SEQ_WATCHDOG_EN
            wait_q  <= wait_d;
            err_q   <= err_d;
`endif
        end
    end

    assign PH0       = ph_q[5:4];
    assign PH1       = ph_q[3:2];
    assign PH2       = ph_q[1:0];
    assign phase     = phase_q;
    assign busy      = busy_q;
    assign instr_cnt = cnt_q;

endmodule
